// File: rtl/tetris_pixel_renderer.sv
// Pixel-colour stage: tracks the board cell under the beam with counters, queries tetris for
// the cell contents and maps kind, frame and grid lines to 12-bit RGB one pixel strobe later.
module tetris_pixel_renderer #(
  parameter int          X0     = 220,
  parameter int          Y0     = 40,
  parameter int          CELL   = 20,
  parameter int          COLS   = 10,
  parameter int          ROWS   = 20,
  parameter logic [11:0] BG     = 12'h111,
  parameter logic [11:0] GRID   = 12'h222,
  parameter logic [11:0] BORDER = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        visible,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [3:0]  cell_x,
  output logic [4:0]  cell_y,
  input  logic [2:0]  cell_kind,
  output logic [11:0] rgb
);

  localparam int          SW       = $clog2(CELL);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL - 1);
  localparam logic [3:0]  COL_LAST = 4'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);
  localparam logic [9:0]  X0_P     = 10'(X0);
  localparam logic [9:0]  Y0_P     = 10'(Y0);
  localparam logic [9:0]  GX_HI    = 10'(X0 + COLS * CELL - 1);
  localparam logic [9:0]  GY_HI    = 10'(Y0 + ROWS * CELL - 1);
  localparam logic [9:0]  BX_LO    = 10'(X0 - 2);
  localparam logic [9:0]  BX_HI    = 10'(X0 + COLS * CELL + 1);
  localparam logic [9:0]  BY_LO    = 10'(Y0 - 2);
  localparam logic [9:0]  BY_HI    = 10'(Y0 + ROWS * CELL + 1);

  logic [SW-1:0] sub_x, sub_y, sub_x_n, sub_y_n;
  logic [3:0]    cell_x_n;
  logic [4:0]    cell_y_n;
  logic          in_x, in_y, row_lock, in_x_n, in_y_n, row_lock_n;
  logic          border_n;
  logic          in_board_d, grid_d, border_d, visible_d;
  logic          stage_b_pend;
  logic [2:0]    kind_d;
  logic [11:0]   rgb_n;

  function automatic logic [11:0] palette(input logic [2:0] k);
    case (k)
      3'd1:    return 12'h09D;
      3'd2:    return 12'h04F;
      3'd3:    return 12'hD90;
      3'd4:    return 12'hFF0;
      3'd5:    return 12'h0F3;
      3'd6:    return 12'h80C;
      3'd7:    return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  // Next tracker state for the pixel being presented; stage A latches these so the
  // registered cell_x/cell_y query and the latched flags describe the same pixel.
  always_comb begin
    sub_x_n  = sub_x;
    cell_x_n = cell_x;
    in_x_n   = in_x;
    if (pixel_x == X0_P) begin
      sub_x_n  = '0;
      cell_x_n = '0;
      in_x_n   = 1'b1;
    end else if (in_x) begin
      if (sub_x == SUB_LAST) begin
        sub_x_n = '0;
        if (cell_x == COL_LAST) begin
          cell_x_n = '0;
          in_x_n   = 1'b0;
        end else begin
          cell_x_n = cell_x + 4'd1;
        end
      end else begin
        sub_x_n = sub_x + 1'b1;
      end
    end

    sub_y_n    = sub_y;
    cell_y_n   = cell_y;
    in_y_n     = in_y;
    row_lock_n = row_lock;
    if (pixel_x == '0) begin
      if (pixel_y == Y0_P) begin
        sub_y_n    = '0;
        cell_y_n   = '0;
        in_y_n     = 1'b1;
        row_lock_n = 1'b1;
      end else if (in_y) begin
        if (sub_y == SUB_LAST) begin
          sub_y_n = '0;
          if (cell_y == ROW_LAST) begin
            cell_y_n = '0;
            in_y_n   = 1'b0;
          end else begin
            cell_y_n = cell_y + 5'd1;
          end
        end else begin
          sub_y_n = sub_y + 1'b1;
        end
      end
    end

    // Frame is geometric so it stays drawn even while row_lock is still clear.
    border_n = (pixel_x >= BX_LO) && (pixel_x <= BX_HI) &&
               (pixel_y >= BY_LO) && (pixel_y <= BY_HI) &&
               !((pixel_x >= X0_P) && (pixel_x <= GX_HI) &&
                 (pixel_y >= Y0_P) && (pixel_y <= GY_HI));

    if (!visible_d)       rgb_n = 12'h000;
    else if (border_d)    rgb_n = BORDER;
    else if (in_board_d) begin
      if (kind_d != 3'd0) rgb_n = palette(kind_d);
      else if (grid_d)    rgb_n = GRID;
      else                rgb_n = 12'h000;
    end else              rgb_n = BG;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_x        <= '0;
      sub_y        <= '0;
      cell_x       <= '0;
      cell_y       <= '0;
      in_x         <= 1'b0;
      in_y         <= 1'b0;
      row_lock     <= 1'b0;
      in_board_d   <= 1'b0;
      grid_d       <= 1'b0;
      border_d     <= 1'b0;
      visible_d    <= 1'b0;
      stage_b_pend <= 1'b0;
      kind_d       <= '0;
      rgb          <= '0;
    end else begin
      stage_b_pend <= p_tick;
      // Tetris answers the query registered on the strobe edge by the following clk.
      if (stage_b_pend) kind_d <= cell_kind;
      if (p_tick) begin
        sub_x      <= sub_x_n;
        sub_y      <= sub_y_n;
        cell_x     <= cell_x_n;
        cell_y     <= cell_y_n;
        in_x       <= in_x_n;
        in_y       <= in_y_n;
        row_lock   <= row_lock_n;
        in_board_d <= in_x_n & in_y_n & row_lock_n;
        grid_d     <= (sub_x_n == '0) | (sub_y_n == '0);
        border_d   <= border_n;
        visible_d  <= visible;
        rgb        <= rgb_n;
      end
    end
  end

endmodule

// File: tb/tb_tetris_pixel_renderer.sv
// Bench for tetris_pixel_renderer: drives shortened scanlines with random visibility and board
// contents, predicts every pixel colour from board geometry and checks it one strobe later.
`timescale 1ns/1ps
module tb_tetris_pixel_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        visible;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [3:0]  cell_x;
  logic [4:0]  cell_y;
  logic [2:0]  cell_kind;
  logic [11:0] rgb;

  int checks   = 0;
  int failures = 0;
  int issue_cnt = 0;
  int tick_seen = 0;
  int mode = 0;
  bit locked = 1'b0;
  logic [2:0]  kind_tbl [0:9][0:19];
  logic [31:0] exp_q[$];
  bit          full_line [0:511];

  always #10 clk = ~clk;

  tetris_pixel_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (p_tick),
    .visible   (visible),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .cell_x    (cell_x),
    .cell_y    (cell_y),
    .cell_kind (cell_kind),
    .rgb       (rgb)
  );

  // Tetris board model: answers whatever cell is being queried.
  function automatic logic [2:0] kind_of(input int cx, input int cy);
    if (cx < 0 || cx > 9 || cy < 0 || cy > 19) return 3'd0;
    case (mode)
      0:       return 3'd0;
      1:       return 3'((cx + cy) % 8);
      2:       return ((cx + cy) % 2 == 1) ? 3'd7 : 3'd0;
      default: return kind_tbl[cx][cy];
    endcase
  endfunction

  always_comb cell_kind = kind_of(int'(cell_x), int'(cell_y));

  function automatic logic [11:0] pal(input logic [2:0] k);
    case (k)
      3'd1:    return 12'h09D;
      3'd2:    return 12'h04F;
      3'd3:    return 12'hD90;
      3'd4:    return 12'hFF0;
      3'd5:    return 12'h0F3;
      3'd6:    return 12'h80C;
      3'd7:    return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] model_rgb(input int x, input int y, input bit vis, input bit lk);
    bit in_frame = (x >= 218) && (x <= 421) && (y >= 38) && (y <= 441);
    bit in_geo   = (x >= 220) && (x <= 419) && (y >= 40) && (y <= 439);
    logic [2:0] k;
    if (!vis) return 12'h000;
    if (in_frame && !in_geo) return 12'hFFF;
    if (in_geo && lk) begin
      k = kind_of((x - 220) / 20, (y - 40) / 20);
      if (k != 3'd0) return pal(k);
      if ((x - 220) % 20 == 0 || (y - 40) % 20 == 0) return 12'h222;
      return 12'h000;
    end
    return 12'h111;
  endfunction

  function automatic bit rand_vis();
    return $urandom_range(0, 11) != 0;
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    p_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
    if (cell_x !== 4'd0) begin failures++; $display("FAIL reset_cell_x got=%0d exp=0", cell_x); end
    if (cell_y !== 5'd0) begin failures++; $display("FAIL reset_cell_y got=%0d exp=0", cell_y); end
    reset  = 1'b0;
    exp_q.delete();
    locked = 1'b0;
  endtask

  task automatic send_pixel(input int x, input int y, input bit vis);
    int ecx, ecy;
    if (x == 0 && y == 40) locked = 1'b1;
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    visible = vis;
    p_tick  = 1'b1;
    exp_q.push_back({20'(issue_cnt), model_rgb(x, y, vis, locked)});
    issue_cnt++;
    @(posedge clk);
    #1;
    ecx = (x >= 220 && x <= 419) ? (x - 220) / 20 : 0;
    ecy = (locked && y >= 40 && y <= 439) ? (y - 40) / 20 : 0;
    checks += 2;
    if (int'(cell_x) != ecx) begin
      failures++;
      $display("FAIL query_cell_x x=%0d y=%0d got=%0d exp=%0d", x, y, cell_x, ecx);
    end
    if (int'(cell_y) != ecy) begin
      failures++;
      $display("FAIL query_cell_y x=%0d y=%0d got=%0d exp=%0d", x, y, cell_y, ecy);
    end
    p_tick = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int m, input int reset_line);
    mode = m;
    for (int i = 0; i < 512; i++) full_line[i] = 1'b0;
    foreach (full_line[i]) if (i == 38 || i == 39 || i == 40 || i == 41 || i == 60 ||
                               i == 65 || i == 439 || i == 440 || i == 441) full_line[i] = 1'b1;
    for (int i = 0; i < 12; i++) full_line[$urandom_range(30, 449)] = 1'b1;
    if (reset_line >= 0) full_line[reset_line] = 1'b0;
    for (int y = 30; y < 450; y++) begin
      send_pixel(0, y, rand_vis());
      if (full_line[y]) begin
        for (int x = 210; x <= 430; x++) send_pixel(x, y, rand_vis());
      end else begin
        if (y == reset_line) do_reset();
        send_pixel(100, y, rand_vis());
        send_pixel(218, y, rand_vis());
      end
    end
  endtask

  // Monitor: the colour for the pixel issued on strobe n appears after strobe n+1.
  initial begin
    int cur;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      if (p_tick && !reset) begin
        cur = tick_seen;
        tick_seen++;
        #2;
        if (exp_q.size() > 0 && exp_q[0][31:12] == 20'(cur - 1)) begin
          e = exp_q.pop_front();
          checks++;
          if (rgb !== e[11:0]) begin
            failures++;
            $display("FAIL rgb tick=%0d got=%h exp=%h", cur - 1, rgb, e[11:0]);
          end
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    p_tick  = 1'b0;
    visible = 1'b0;
    pixel_x = '0;
    pixel_y = '0;
    foreach (kind_tbl[i, j]) kind_tbl[i][j] = 3'($urandom_range(0, 7));
    #1;
    do_reset();
    run_frame(0, -1);
    run_frame(1, -1);
    run_frame(2, -1);
    run_frame(3, 100);
    run_frame(3, -1);
    send_pixel(1, 0, 1'b0);
    send_pixel(2, 0, 1'b0);
    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
